// File: rtl/sram_ctrl_pkg.sv
// Shared memory-stage transaction types used by the mem stage and its downstream slaves.
package sram_ctrl_pkg;

   typedef logic [31:0] addr;
   typedef logic [31:0] mtrans;

   typedef struct packed {
      addr         a;
      logic [3:0]  be;
      logic [31:0] d;
      logic        we;
   } mreq_t;

endpackage

// File: rtl/sram_pad.sv
// Bidirectional SRAM data pad: splits the shared data bus into drive and sense halves.
module sram_pad (
   input  logic [31:0] d_o,
   input  logic        d_oe,
   output logic [31:0] d_i,
   inout  wire  [31:0] pad
);

   assign pad = d_oe ? d_o : 'z;
   assign d_i = pad;

endmodule

// File: rtl/sram_ctrl.sv
// Single-outstanding asynchronous-SRAM slave for the mem stage, with programmable wait states.
module sram_ctrl
   import sram_ctrl_pkg::*;
#(
   parameter int WAIT_CYCLES = 1,
   parameter int ADDR_W      = 20
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mem_req_valid,
   output logic              mem_req_ready,
   input  mreq_t             mem_req_data,
   output logic              mem_resp_valid,
   input  logic              mem_resp_ready,
   output mtrans             mem_resp_data,
   output logic [ADDR_W-1:0] sram_a,
   output logic [31:0]       sram_d_o,
   input  logic [31:0]       sram_d_i,
   output logic              sram_d_oe,
   output logic              sram_ce_n,
   output logic              sram_oe_n,
   output logic              sram_we_n,
   output logic [3:0]        sram_be_n
);

   localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

   typedef enum logic [2:0] {IDLE, SETUP, ACCESS, HOLD, RESP} state_e;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   mreq_t             req_q, req_d;
   mtrans             resp_data_q, resp_data_d;
   logic              req_ready_q, req_ready_d;
   logic              resp_valid_q, resp_valid_d;
   logic [ADDR_W-1:0] a_q, a_d;
   logic [31:0]       d_o_q, d_o_d;
   logic              d_oe_q, d_oe_d;
   logic              ce_n_q, ce_n_d;
   logic              oe_n_q, oe_n_d;
   logic              we_n_q, we_n_d;
   logic [3:0]        be_n_q, be_n_d;
   logic              unused_a;

   // Address bits outside the SRAM word range are dropped by design.
   assign unused_a = ^{req_q.a[1:0], req_q.a[31:ADDR_W+2]};

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      req_d       = req_q;
      resp_data_d = resp_data_q;
      case (state_q)
         IDLE: begin
            if (mem_req_valid && req_ready_q) begin
               req_d   = mem_req_data;
               state_d = SETUP;
            end
         end
         SETUP: begin
            cnt_d   = CNT_W'(WAIT_CYCLES);
            state_d = ACCESS;
         end
         ACCESS: begin
            if (cnt_q == '0) begin
               if (req_q.we) begin
                  state_d = HOLD;
               end else begin
                  resp_data_d = sram_d_i;
                  state_d     = RESP;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         HOLD: begin
            resp_data_d = '0;
            state_d     = RESP;
         end
         RESP: begin
            if (mem_resp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Pins are decoded from the next state so every output comes straight off a flop.
      ce_n_d       = !(state_d inside {SETUP, ACCESS, HOLD});
      oe_n_d       = !(state_d == ACCESS && !req_d.we);
      we_n_d       = !(state_d == ACCESS && req_d.we);
      d_oe_d       = req_d.we && (state_d inside {SETUP, ACCESS, HOLD});
      be_n_d       = ce_n_d ? 4'hF : ~req_d.be;
      a_d          = req_d.a[ADDR_W+1:2];
      d_o_d        = req_d.d;
      resp_valid_d = (state_d == RESP);
      req_ready_d  = (state_d == IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         req_q        <= '0;
         resp_data_q  <= '0;
         req_ready_q  <= 1'b1;
         resp_valid_q <= 1'b0;
         a_q          <= '0;
         d_o_q        <= '0;
         d_oe_q       <= 1'b0;
         ce_n_q       <= 1'b1;
         oe_n_q       <= 1'b1;
         we_n_q       <= 1'b1;
         be_n_q       <= 4'hF;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         req_q        <= req_d;
         resp_data_q  <= resp_data_d;
         req_ready_q  <= req_ready_d;
         resp_valid_q <= resp_valid_d;
         a_q          <= a_d;
         d_o_q        <= d_o_d;
         d_oe_q       <= d_oe_d;
         ce_n_q       <= ce_n_d;
         oe_n_q       <= oe_n_d;
         we_n_q       <= we_n_d;
         be_n_q       <= be_n_d;
      end
   end

   assign mem_req_ready  = req_ready_q;
   assign mem_resp_valid = resp_valid_q;
   assign mem_resp_data  = resp_data_q;
   assign sram_a         = a_q;
   assign sram_d_o       = d_o_q;
   assign sram_d_oe      = d_oe_q;
   assign sram_ce_n      = ce_n_q;
   assign sram_oe_n      = oe_n_q;
   assign sram_we_n      = we_n_q;
   assign sram_be_n      = be_n_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: three instances (1, 0 and 3 wait states) against a word-array SRAM model and scoreboard.
module tb_sram_ctrl;
   import sram_ctrl_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic mem_init = 1'b1;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int acc_cnt = 0;
   int resp_cnt = 0;

   logic        req_valid[3], req_ready[3], resp_valid[3], resp_ready[3];
   mreq_t       req_data[3];
   mtrans       resp_data[3];
   logic [19:0] sa[3];
   logic [31:0] d_o[3], d_i[3], wd[3];
   logic        d_oe[3], ce_n[3], oe_n[3], we_n[3];
   logic [3:0]  be_n[3];
   logic [31:0] mem[3][1024];
   logic [31:0] ref_mem[3][1024];
   wire  [31:0] dq;

   function automatic logic [31:0] init_word(input int k, input int i);
      if (i == 'h41) return 32'hDEAD_BEEF;
      return {i[15:0] ^ 16'h5A5A, 16'(k * 4099 + i * 77)};
   endfunction

   for (genvar g = 0; g < 3; g++) begin : g_dut
      sram_ctrl #(.WAIT_CYCLES((g == 0) ? 1 : (g == 1) ? 0 : 3), .ADDR_W(20)) u_dut (
         .clk            (clk),
         .rst            (rst),
         .mem_req_valid  (req_valid[g]),
         .mem_req_ready  (req_ready[g]),
         .mem_req_data   (req_data[g]),
         .mem_resp_valid (resp_valid[g]),
         .mem_resp_ready (resp_ready[g]),
         .mem_resp_data  (resp_data[g]),
         .sram_a         (sa[g]),
         .sram_d_o       (d_o[g]),
         .sram_d_i       (d_i[g]),
         .sram_d_oe      (d_oe[g]),
         .sram_ce_n      (ce_n[g]),
         .sram_oe_n      (oe_n[g]),
         .sram_we_n      (we_n[g]),
         .sram_be_n      (be_n[g])
      );
      if (g == 0) begin : g_pad
         assign dq = !oe_n[0] ? mem[0][sa[0][9:0]] : 'z;
         sram_pad u_pad (.d_o(d_o[0]), .d_oe(d_oe[0]), .d_i(d_i[0]), .pad(dq));
         assign wd[0] = dq;
      end else begin : g_nopad
         assign d_i[g] = !oe_n[g] ? mem[g][sa[g][9:0]] : 32'h0BAD_F00D;
         assign wd[g]  = d_o[g];
      end
   end

   // SRAM device model: byte-lane writes while ce_n and we_n are both low.
   always @(posedge clk) begin
      if (mem_init) begin
         for (int k = 0; k < 3; k++)
            for (int i = 0; i < 1024; i++) mem[k][i] <= init_word(k, i);
      end else begin
         for (int k = 0; k < 3; k++)
            if (!ce_n[k] && !we_n[k])
               for (int b = 0; b < 4; b++)
                  if (!be_n[k][b]) mem[k][sa[k][9:0]][8*b +: 8] <= wd[k][8*b +: 8];
      end
   end

   always @(posedge clk) begin
      for (int k = 0; k < 3; k++) begin
         if (!rst && req_valid[k] && req_ready[k]) acc_cnt <= acc_cnt + 1;
         if (!rst && resp_valid[k] && resp_ready[k]) resp_cnt <= resp_cnt + 1;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst)
         for (int k = 0; k < 3; k++)
            chk("pad_dir", {oe_n[k] | we_n[k], oe_n[k] | ~d_oe[k]}, 2'b11);
   end

   task automatic accept(input int k, input mreq_t r);
      req_data[k]  = r;
      req_valid[k] = 1'b1;
      @(negedge clk);
      chk("req_idle", {resp_valid[k], req_ready[k], ce_n[k]}, 3'b011);
      @(posedge clk);
      #1;
      req_valid[k]      = 1'b0;
      req_data[k].a     = $urandom;
      req_data[k].d     = $urandom;
      req_data[k].be    = 4'($urandom);
      req_data[k].we    = ~r.we;
   endtask

   function automatic mreq_t mk_req(input logic we, input logic [9:0] wa,
                                    input logic [3:0] be, input logic [31:0] d);
      mreq_t r;
      logic [9:0] hi;
      logic [1:0] lo;
      hi   = 10'($urandom);
      lo   = 2'($urandom);
      r.a  = {hi, 10'h0, wa, lo};
      r.be = be;
      r.d  = d;
      r.we = we;
      return r;
   endfunction

   // One request end to end; expected pin timeline follows from the wait-state count.
   task automatic txn(input int k, input logic we, input logic [9:0] wa, input logic [3:0] be,
                      input logic [31:0] d, input int hold);
      int          w, last, rc;
      logic [31:0] exp_d;
      w     = (k == 0) ? 1 : (k == 1) ? 0 : 3;
      last  = we ? w + 3 : w + 2;
      rc    = last + 1;
      exp_d = we ? 32'h0 : ref_mem[k][wa];
      if (we)
         for (int b = 0; b < 4; b++)
            if (be[b]) ref_mem[k][wa][8*b +: 8] = d[8*b +: 8];
      accept(k, mk_req(we, wa, be, d));
      for (int c = 1; c <= rc; c++) begin
         @(negedge clk);
         chk("ctl", {ce_n[k], oe_n[k], we_n[k], d_oe[k], resp_valid[k], req_ready[k]},
             {c > last, !(!we && c >= 2 && c <= w + 2), !(we && c >= 2 && c <= w + 2),
              we && c <= w + 3, c == rc, 1'b0});
         if (c <= last) chk("addr_be", {sa[k], be_n[k]}, {10'h0, wa, ~be});
         if (we && c <= last) chk("wdata", d_o[k], d);
      end
      chk("resp_data", resp_data[k], exp_d);
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         chk("resp_hold", {resp_valid[k], req_ready[k], ce_n[k], resp_data[k]}, {3'b101, exp_d});
      end
      resp_ready[k] = 1'b1;
      @(posedge clk);
      #1;
      resp_ready[k] = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog observed=still_running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] old;
      int          bad;
      int          k;
      for (int j = 0; j < 3; j++) begin
         req_valid[j]  = 1'b0;
         resp_ready[j] = 1'b0;
         req_data[j]   = '0;
         for (int i = 0; i < 1024; i++) ref_mem[j][i] = init_word(j, i);
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int j = 0; j < 3; j++)
         chk("reset", {req_ready[j], resp_valid[j], ce_n[j], oe_n[j], we_n[j], be_n[j], d_oe[j], sa[j]},
             {5'b10111, 4'hF, 1'b0, 20'h0});
      @(posedge clk);
      #1;
      rst      = 1'b0;
      mem_init = 1'b0;

      txn(0, 1'b0, 10'h41, 4'hF, 32'h0, 0);
      old = ref_mem[0][2];
      txn(0, 1'b1, 10'd2, 4'b1100, 32'hAB00_0000, 0);
      chk("write_bytes", mem[0][2], {16'hAB00, old[15:0]});
      txn(0, 1'b0, 10'h41, 4'hF, 32'h0, 3);
      txn(0, 1'b1, 10'd7, 4'h0, 32'h1234_5678, 0);
      txn(1, 1'b0, 10'h41, 4'hF, 32'h0, 0);
      txn(1, 1'b1, 10'd9, 4'b0101, 32'hCAFE_F00D, 1);
      txn(2, 1'b0, 10'h41, 4'hF, 32'h0, 0);
      txn(2, 1'b1, 10'd9, 4'b1010, 32'h5566_7788, 2);

      // Reset during the write strobe: the request vanishes without a response.
      accept(0, mk_req(1'b1, 10'd1023, 4'hF, 32'hFFFF_FFFF));
      @(negedge clk);
      @(negedge clk);
      chk("rst_pre", we_n[0], 1'b0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rst_abort", {ce_n[0], oe_n[0], we_n[0], d_oe[0], resp_valid[0], req_ready[0]}, 6'b111001);
      for (int n = 0; n < 8; n++) begin
         @(negedge clk);
         chk("rst_no_resp", resp_valid[0], 1'b0);
      end
      @(posedge clk);
      #1;
      txn(0, 1'b0, 10'h41, 4'hF, 32'h0, 0);

      for (int n = 0; n < 1150; n++) begin
         k = (n < 1000) ? 0 : (n < 1075) ? 1 : 2;
         txn(k, 1'($urandom), 10'($urandom_range(0, 1022)), 4'($urandom), $urandom,
             ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0);
      end

      bad = 0;
      for (int j = 0; j < 3; j++)
         for (int i = 0; i < 1023; i++)
            if (mem[j][i] !== ref_mem[j][i]) bad++;
      chk("mem_sweep", bad, 0);
      chk("one_resp_per_req", resp_cnt, acc_cnt - 1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
